// File: rtl/rio_user_pkg.sv
// Shared definitions for the NWRITE user-side test-packet generator and checker.
// Holds the checker state encoding, the error codes and the last-beat tkeep rule.
package rio_user_pkg;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_RUNT       = 3'd1;
    localparam logic [2:0] ERR_HDR        = 3'd2;
    localparam logic [2:0] ERR_DATA       = 3'd3;
    localparam logic [2:0] ERR_KEEP       = 3'd4;
    localparam logic [2:0] ERR_EARLY_LAST = 3'd5;
    localparam logic [2:0] ERR_NO_LAST    = 3'd6;

    // r is the payload size modulo 8; byte 0 of a beat sits on tkeep bit 7.
    function automatic logic [7:0] last_keep(input logic [2:0] r);
        case (r)
            3'd0:    last_keep = 8'hff;
            3'd1:    last_keep = 8'h80;
            3'd2:    last_keep = 8'hc0;
            3'd3:    last_keep = 8'he0;
            3'd4:    last_keep = 8'hf0;
            3'd5:    last_keep = 8'hf8;
            3'd6:    last_keep = 8'hfc;
            default: last_keep = 8'hfe;
        endcase
    endfunction

endpackage

// File: rtl/nwr_pattern_cmp.sv
// Expected-pattern generator for the NWRITE checker: holds the header, the beat
// index k and the beat count N, and presents the expected data and last-beat tkeep.
module nwr_pattern_cmp
    import rio_user_pkg::*;
(
    input  logic        log_clk,
    input  logic        log_rst,
    input  logic        load,
    input  logic        step,
    input  logic [63:0] hdr,
    output logic [63:0] exp_data,
    output logic [7:0]  exp_keep,
    output logic        at_last
);

    logic [63:0] h_q;
    logic [12:0] k_q;
    logic [12:0] n_q;
    logic [12:0] size;

    // S = H[11:0] + 1 needs 13 bits so that a 4096-byte payload does not wrap.
    assign size = {1'b0, hdr[11:0]} + 13'd1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            h_q <= '0;
            k_q <= '0;
            n_q <= '0;
        end else if (load) begin
            h_q <= hdr;
            k_q <= 13'd1;
            n_q <= (size + 13'd7) >> 3;
        end else if (step) begin
            k_q <= k_q + 13'd1;
        end
    end

    assign exp_data = h_q + {51'd0, k_q};
    assign exp_keep = last_keep(h_q[2:0] + 3'd1);
    assign at_last  = (k_q == n_q);

endmodule

// File: rtl/nwr_user_checker.sv
// Receive-side sink for NWRITE payloads: checks each packet against the test-packet
// format and reports per-packet done/error pulses plus saturating counters.
module nwr_user_checker
    import rio_user_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit CHECK_DATA = 1'b1
) (
    input  logic             log_clk,
    input  logic             log_rst,
    input  logic             rx_enable_in,
    input  logic [63:0]      user_tdata_in,
    input  logic             user_tvalid_in,
    input  logic [7:0]       user_tkeep_in,
    input  logic             user_tlast_in,
    output logic             user_tready_o,
    output logic             pkt_done_o,
    output logic             pkt_err_o,
    output logic [2:0]       err_code_o,
    output logic [11:0]      last_size_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    state_t      state, state_nx;
    logic        accept;
    logic        term;
    logic        cmp_load, cmp_step;
    logic [2:0]  code_nx;
    logic [2:0]  pend_q;
    logic [63:0] exp_data;
    logic [7:0]  exp_keep;
    logic        at_last;

    assign accept = user_tvalid_in && user_tready_o;

    nwr_pattern_cmp u_cmp (
        .log_clk  (log_clk),
        .log_rst  (log_rst),
        .load     (cmp_load),
        .step     (cmp_step),
        .hdr      (user_tdata_in),
        .exp_data (exp_data),
        .exp_keep (exp_keep),
        .at_last  (at_last)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        term     = 1'b0;
        code_nx  = ERR_NONE;
        cmp_load = 1'b0;
        cmp_step = 1'b0;
        if (accept) begin
            case (state)
                HDR: begin
                    cmp_load = 1'b1;
                    if (user_tlast_in) begin
                        term    = 1'b1;
                        code_nx = ERR_RUNT;
                    end else if (|user_tdata_in[63:12]) begin
                        state_nx = DRAIN;
                        code_nx  = ERR_HDR;
                    end else begin
                        state_nx = DATA;
                    end
                end
                DATA: begin
                    // Lowest code wins when several checks fail on the same beat.
                    if (CHECK_DATA && (user_tdata_in != exp_data))
                        code_nx = ERR_DATA;
                    else if (!user_tlast_in && (user_tkeep_in != 8'hff))
                        code_nx = ERR_KEEP;
                    else if (user_tlast_in && !at_last)
                        code_nx = ERR_EARLY_LAST;
                    else if (at_last && !user_tlast_in)
                        code_nx = ERR_NO_LAST;
                    else if (at_last && (user_tkeep_in != exp_keep))
                        code_nx = ERR_KEEP;

                    if (user_tlast_in)
                        term = 1'b1;
                    else if (code_nx != ERR_NONE)
                        state_nx = DRAIN;
                    else
                        cmp_step = 1'b1;
                end
                default: begin
                    code_nx = pend_q;
                    term    = user_tlast_in;
                end
            endcase
            if (term)
                state_nx = HDR;
        end
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state         <= HDR;
            pend_q        <= ERR_NONE;
            user_tready_o <= 1'b0;
            pkt_done_o    <= 1'b0;
            pkt_err_o     <= 1'b0;
            err_code_o    <= ERR_NONE;
            last_size_o   <= '0;
            pkt_cnt_o     <= '0;
            err_cnt_o     <= '0;
        end else begin
            state         <= state_nx;
            user_tready_o <= (state_nx == DRAIN) ? 1'b1 : rx_enable_in;
            pkt_done_o    <= term;
            pkt_err_o     <= term && (code_nx != ERR_NONE);
            if (accept && (state_nx == DRAIN))
                pend_q <= code_nx;
            if (accept && (state == HDR))
                last_size_o <= user_tdata_in[11:0];
            if (term) begin
                if (pkt_cnt_o != '1)
                    pkt_cnt_o <= pkt_cnt_o + 1'b1;
                if (code_nx != ERR_NONE) begin
                    err_code_o <= code_nx;
                    if (err_cnt_o != '1)
                        err_cnt_o <= err_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nwr_user_checker.sv
// Directed bench for nwr_user_checker: drives test packets (good and corrupted) and
// checks done/error pulses, error codes, counters and ready behaviour.
module tb_nwr_user_checker;

    localparam int CNT_W = 16;

    logic             log_clk;
    logic             log_rst;
    logic             rx_enable_in;
    logic [63:0]      user_tdata_in;
    logic             user_tvalid_in;
    logic [7:0]       user_tkeep_in;
    logic             user_tlast_in;
    logic             user_tready_o;
    logic             pkt_done_o;
    logic             pkt_err_o;
    logic [2:0]       err_code_o;
    logic [11:0]      last_size_o;
    logic [CNT_W-1:0] pkt_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int cyc       = 0;
    bit toggle_mode = 1'b0;
    bit chk_ready   = 1'b0;

    logic [7:0] keep_tbl [8] = '{8'hff, 8'h80, 8'hc0, 8'he0, 8'hf0, 8'hf8, 8'hfc, 8'hfe};

    nwr_user_checker #(.CNT_W(CNT_W), .CHECK_DATA(1'b1)) dut (
        .log_clk        (log_clk),
        .log_rst        (log_rst),
        .rx_enable_in   (rx_enable_in),
        .user_tdata_in  (user_tdata_in),
        .user_tvalid_in (user_tvalid_in),
        .user_tkeep_in  (user_tkeep_in),
        .user_tlast_in  (user_tlast_in),
        .user_tready_o  (user_tready_o),
        .pkt_done_o     (pkt_done_o),
        .pkt_err_o      (pkt_err_o),
        .err_code_o     (err_code_o),
        .last_size_o    (last_size_o),
        .pkt_cnt_o      (pkt_cnt_o),
        .err_cnt_o      (err_cnt_o)
    );

    initial log_clk = 1'b0;
    always #5 log_clk = ~log_clk;

    always @(negedge log_clk)
        if (pkt_done_o === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: ready must mirror the enable sampled at this edge when checking is on.
    task automatic tick();
        logic pe;
        pe = rx_enable_in;
        @(posedge log_clk);
        #1;
        cyc++;
        if (chk_ready) check("ready_follows_enable", {63'd0, user_tready_o}, {63'd0, pe});
        if (toggle_mode && (cyc % 3 == 0)) rx_enable_in = ~rx_enable_in;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] keep, input logic last, input bit gaps);
        logic acc;
        int   tries;
        if (gaps) begin
            user_tvalid_in = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        user_tvalid_in = 1'b1;
        user_tdata_in  = d;
        user_tkeep_in  = keep;
        user_tlast_in  = last;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            @(negedge log_clk);
            acc = user_tready_o;
            tick();
            tries++;
        end
        if (!acc) check("beat_accept_timeout", {63'd0, acc}, 64'd1);
    endtask

    // last_at = 0 -> normal tlast on beat N; bad_k corrupts beat k to H+k+1.
    task automatic send_pkt(input int s, input int last_at, input int bad_k,
                            input logic [7:0] keep_ovr, input bit gaps);
        logic [63:0] h, d;
        logic [7:0]  keep;
        int n, nb;
        h  = 64'(s - 1);
        n  = (s + 7) >> 3;
        nb = (last_at != 0) ? last_at : n;
        send_beat(h, 8'hff, 1'b0, gaps);
        for (int k = 1; k <= nb; k++) begin
            d = h + 64'(k);
            if (k == bad_k) d = h + 64'(k + 1);
            keep = 8'hff;
            if (k == nb && last_at == 0)
                keep = (keep_ovr != 8'h00) ? keep_ovr : keep_tbl[s % 8];
            send_beat(d, keep, (k == nb), gaps);
        end
    endtask

    task automatic expect_done(input string tag, input logic err);
        check({tag, "_done"}, {63'd0, pkt_done_o}, 64'd1);
        check({tag, "_err"},  {63'd0, pkt_err_o},  {63'd0, err});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {63'd0, user_tready_o}, 64'd0);
        check({tag, "_done"},  {63'd0, pkt_done_o},    64'd0);
        check({tag, "_err"},   {63'd0, pkt_err_o},     64'd0);
        check({tag, "_code"},  {61'd0, err_code_o},    64'd0);
        check({tag, "_size"},  {52'd0, last_size_o},   64'd0);
        check({tag, "_pkts"},  64'(pkt_cnt_o),         64'd0);
        check({tag, "_errs"},  64'(err_cnt_o),         64'd0);
    endtask

    initial begin
        int sizes [6] = '{256, 257, 259, 513, 1, 4096};
        int base;

        log_rst        = 1'b1;
        rx_enable_in   = 1'b0;
        user_tvalid_in = 1'b0;
        user_tdata_in  = '0;
        user_tkeep_in  = '0;
        user_tlast_in  = 1'b0;
        repeat (3) @(posedge log_clk);
        #1;
        check_all_zero("reset");
        log_rst      = 1'b0;
        rx_enable_in = 1'b1;

        // Good packets back to back, valid held high throughout.
        for (int i = 0; i < 6; i++) begin
            send_pkt(sizes[i], 0, 0, 8'h00, 1'b0);
            expect_done($sformatf("good_s%0d", sizes[i]), 1'b0);
            if (i == 0) check("size_after_256", {52'd0, last_size_o}, 64'h0ff);
        end
        user_tvalid_in = 1'b0;
        tick();
        check("good_pkts", 64'(pkt_cnt_o), 64'd6);
        check("good_errs", 64'(err_cnt_o), 64'd0);
        check("good_size", {52'd0, last_size_o}, 64'hfff);
        check("good_done_pulses", 64'(done_cnt), 64'd6);

        // Corrupt data beat, then a good packet.
        send_pkt(260, 0, 5, 8'h00, 1'b0);
        expect_done("data_err", 1'b1);
        check("data_err_code", {61'd0, err_code_o}, 64'd3);
        check("data_err_errs", 64'(err_cnt_o), 64'd1);
        send_pkt(8, 0, 0, 8'h00, 1'b0);
        expect_done("after_data_err", 1'b0);
        check("after_data_err_pkts", 64'(pkt_cnt_o), 64'd8);
        check("after_data_err_code_held", {61'd0, err_code_o}, 64'd3);

        // Wrong residual tkeep on the last beat.
        user_tvalid_in = 1'b0;
        tick();
        base = done_cnt;
        send_pkt(258, 0, 0, 8'ha0, 1'b0);
        expect_done("keep_err", 1'b1);
        check("keep_err_code", {61'd0, err_code_o}, 64'd4);
        user_tvalid_in = 1'b0;
        tick();
        check("keep_err_one_done", 64'(done_cnt), 64'(base + 1));

        // Early tlast on beat 5 of 8.
        send_pkt(64, 5, 0, 8'h00, 1'b0);
        expect_done("early_last", 1'b1);
        check("early_last_code", {61'd0, err_code_o}, 64'd5);
        user_tvalid_in = 1'b0;
        tick();

        // Missing tlast: beat 8 has none, drained until beat 10.
        base = done_cnt;
        send_pkt(64, 10, 0, 8'h00, 1'b0);
        expect_done("no_last", 1'b1);
        check("no_last_code", {61'd0, err_code_o}, 64'd6);
        user_tvalid_in = 1'b0;
        tick();
        check("no_last_one_done", 64'(done_cnt), 64'(base + 1));
        check("no_last_errs", 64'(err_cnt_o), 64'd4);
        check("no_last_pkts", 64'(pkt_cnt_o), 64'd11);

        // Runt: header carrying tlast.
        send_beat(64'h0, 8'hff, 1'b1, 1'b0);
        expect_done("runt", 1'b1);
        check("runt_code", {61'd0, err_code_o}, 64'd1);

        // Bad header, remaining beats drained.
        send_beat(64'h1_0000_00ff, 8'hff, 1'b0, 1'b0);
        check("bad_hdr_no_done_yet", {63'd0, pkt_done_o}, 64'd0);
        send_beat(64'h1234, 8'hff, 1'b0, 1'b0);
        send_beat(64'h5678, 8'hff, 1'b0, 1'b0);
        send_beat(64'h9abc, 8'h80, 1'b1, 1'b0);
        expect_done("bad_hdr", 1'b1);
        check("bad_hdr_code", {61'd0, err_code_o}, 64'd2);
        check("bad_hdr_size", {52'd0, last_size_o}, 64'h0ff);
        check("bad_hdr_errs", 64'(err_cnt_o), 64'd6);
        check("bad_hdr_pkts", 64'(pkt_cnt_o), 64'd13);

        // Valid gaps with the enable toggling every 3 cycles.
        user_tvalid_in = 1'b0;
        tick();
        toggle_mode = 1'b1;
        chk_ready   = 1'b1;
        send_pkt(513, 0, 0, 8'h00, 1'b1);
        expect_done("gaps", 1'b0);
        toggle_mode    = 1'b0;
        chk_ready      = 1'b0;
        rx_enable_in   = 1'b1;
        user_tvalid_in = 1'b0;
        tick();
        check("gaps_pkts", 64'(pkt_cnt_o), 64'd14);
        check("gaps_errs", 64'(err_cnt_o), 64'd6);

        // Reset in the middle of a 512-byte packet (header plus 19 data beats sent).
        send_beat(64'h1ff, 8'hff, 1'b0, 1'b0);
        for (int k = 1; k <= 19; k++)
            send_beat(64'h1ff + 64'(k), 8'hff, 1'b0, 1'b0);
        user_tvalid_in = 1'b0;
        log_rst        = 1'b1;
        #1;
        check_all_zero("mid_reset");
        tick();
        log_rst = 1'b0;
        send_pkt(16, 0, 0, 8'h00, 1'b0);
        expect_done("post_reset", 1'b0);
        check("post_reset_pkts", 64'(pkt_cnt_o), 64'd1);
        check("post_reset_errs", 64'(err_cnt_o), 64'd0);
        check("post_reset_size", {52'd0, last_size_o}, 64'h00f);
        user_tvalid_in = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nwr_user_checker.md
Name: nwr_user_checker

Overview:
- User-side sink at the receive end of the NWRITE path.
- Consumes the 64-bit AXI4-Stream payload that the target side delivers for each received NWRITE packet.
- Checks every packet against the team's test-packet format: header beat, then an incrementing data pattern, then a residual tkeep on the final beat.
- Reports per-packet pass/fail pulses and running counters for bring-up and regression.

Parameters:
- CNT_W, 16, width of the packet and error counters; both saturate at all-ones.
- CHECK_DATA, 1, 1 = compare data beats against the expected pattern; 0 = check only framing and tkeep.

Ports:
- log_clk  input  1  logic clock.
- log_rst  input  1  reset; asynchronous, active-high.
- rx_enable_in  input  1  permits the block to accept beats.
- user_tdata_in  input  64  payload beat.
- user_tvalid_in  input  1  beat valid.
- user_tkeep_in  input  8  byte enables; bit7 = first byte.
- user_tlast_in  input  1  last beat of packet.
- user_tready_o  output  1  beat accept.
- pkt_done_o  output  1  one-cycle pulse when a packet terminates, pass or fail.
- pkt_err_o  output  1  one-cycle pulse coincident with pkt_done_o when the packet failed.
- err_code_o  output  3  cause of the last failed packet; held until the next failure.
- last_size_o  output  12  byte count minus 1 taken from the last header.
- pkt_cnt_o  output  CNT_W  packets completed.
- err_cnt_o  output  CNT_W  packets failed.

Behaviour:
- Reset values: all outputs 0, state HDR.
- Beat accepted = user_tvalid_in && user_tready_o.
- user_tready_o is a register: user_tready_o <= rx_enable_in, so it follows the enable with one cycle latency.
- In DRAIN the ready is forced to 1 regardless of rx_enable_in, so the bad packet is flushed.
- Packet format:
  - Beat 0 is the header H. H[11:0] = S-1, where S is the payload size in bytes (1..4096). H[63:12] must be 0.
  - Beats k = 1..N carry H+k (64-bit wrap), with N = (S+7)>>3 computed in 13-bit arithmetic.
  - Beat N has tlast = 1. Its tkeep is derived from r = S[2:0]: r=0 ff, 1 80, 2 c0, 3 e0, 4 f0, 5 f8, 6 fc, 7 fe.
  - Every non-last beat has tkeep = ff.
- States:
  - HDR: on an accepted beat, latch H and set last_size_o <= H[11:0].
    - tlast=1 -> error code 1 (runt); terminate.
    - H[63:12] != 0 -> error code 2 (bad header); go to DRAIN.
    - Otherwise go to DATA with beat counter k = 1.
  - DATA: on each accepted beat, check in priority order (lowest code wins):
    - tdata != H+k and CHECK_DATA=1 -> code 3.
    - Non-last beat with tkeep != ff -> code 4.
    - tlast=1 with k<N -> code 5 (early last); terminate.
    - k==N with tlast=0 -> code 6 (missing last); go to DRAIN.
    - Beat N with tkeep mismatch -> code 4.
    - An error on a beat with tlast=1 terminates; an error on a beat with tlast=0 goes to DRAIN.
    - Beat N with tlast=1 and no error terminates as a pass.
    - Otherwise k increments.
  - DRAIN: accept and discard beats until an accepted tlast=1, then terminate (still failed).
- Terminate: the cycle after the terminating beat, pkt_done_o=1, pkt_cnt_o increments, state returns to HDR.
  - On failure, pkt_err_o=1, err_cnt_o increments, and err_code_o updates.
  - Terminate counts as one packet even when entered via DRAIN; the DRAIN exit is the terminating beat.
- Counters saturate; they never wrap.
- A beat in the same cycle as terminate pulses belongs to the next packet and is handled in HDR. Throughput is therefore back-to-back, with no dead cycle.
- Gaps in tvalid or in ready do not disturb state or the counter k.
- log_rst mid-packet: state returns to HDR, counters clear, and the partial packet is not counted.

Decomposition:
- Package rio_user_pkg holds:
  - state encoding (HDR, DATA, DRAIN);
  - error-code constants (ERR_NONE=0, RUNT=1, HDR=2, DATA=3, KEEP=4, EARLY_LAST=5, NO_LAST=6);
  - a function returning the expected last-beat tkeep from r. The same function is to be reused by the generator side.
- One sub-module is natural: nwr_pattern_cmp. It registers H, holds k and N, and produces the expected data and expected keep.
- The FSM and counters stay in nwr_user_checker.

Test Plan:
- Sizes S = 256, 257, 259, 513, 1, 4096, back-to-back with valid always high:
  - each packet gets one pkt_done_o, with pkt_err_o=0;
  - pkt_cnt_o=6, err_cnt_o=0;
  - last_size_o=0xfff after the final packet.
- S=260 with beat 5 data corrupted to H+6 -> pkt_err_o=1, err_code_o=3, err_cnt_o=1; the next good S=8 packet passes.
- S=258 (r=2) with last tkeep=a0 instead of c0 -> err_code_o=4, one pkt_done_o.
- S=64 with tlast on beat 5 (N=8) -> code 5 with pkt_done_o the cycle after; S=64 with tlast only on beat 10 -> code 6, DRAIN, and pkt_done_o once, one cycle after beat 10.
- Header with tlast=1 -> code 1; header 0x1_0000_00ff -> code 2, remaining beats drained.
- Random tvalid gaps plus rx_enable_in toggling every 3 cycles with S=513 -> pass, and no beat is accepted while user_tready_o=0.
- log_rst pulsed at beat 20 of S=512 -> all outputs 0; the following S=16 packet passes with pkt_cnt_o=1.
